// File: rtl/dma_priority_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmaRegConfigPkg
// Shared DMA configuration: channel count, pointer width and the arbiter
// state encoding used by dma_priority_arbiter and its interface.
// ---------------------------------------------------------------------------
package dmaRegConfigPkg;

  // Must be a power of two >= 2 so the priority pointer wraps naturally.
  localparam int CHANNELS = 4;
  localparam int PTRWIDTH = $clog2(CHANNELS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    GRANT   = 2'd2
  } arbState_t;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter_if
// Bus-side view of the priority arbiter: DREQ/HLDA/HRQ/DACK pins plus the
// mask/mode/control inputs and the grant status outputs.
//   master : the arbiter (drives HRQ, DACK, activeChannel, grantValid)
//   slave  : the environment (drives requests, HLDA, mask, mode, done)
// ---------------------------------------------------------------------------
interface dma_priority_arbiter_if;
  import dmaRegConfigPkg::*;

  logic [CHANNELS-1:0] DREQ;
  logic                HLDA;
  logic [CHANNELS-1:0] maskBits;
  logic                rotatingPriority;
  logic                controllerDisable;
  logic                transferDone;
  logic                HRQ;
  logic [CHANNELS-1:0] DACK;
  logic [PTRWIDTH-1:0] activeChannel;
  logic                grantValid;

  modport master (
    input  DREQ, HLDA, maskBits, rotatingPriority, controllerDisable, transferDone,
    output HRQ, DACK, activeChannel, grantValid
  );

  modport slave (
    output DREQ, HLDA, maskBits, rotatingPriority, controllerDisable, transferDone,
    input  HRQ, DACK, activeChannel, grantValid
  );

endinterface

// File: rtl/dma_priority_arbiter_priority_encoder_rr.sv
// ---------------------------------------------------------------------------
// priority_encoder_rr
// Combinational wrap-around priority encoder. The channel at i_ptr has the
// highest priority, then i_ptr+1, ... wrapping modulo CHANNELS.
//   i_req    : request vector
//   i_ptr    : highest-priority channel index
//   o_winner : index of the selected channel (0 when nothing requests)
//   o_valid  : any request present
// ---------------------------------------------------------------------------
module priority_encoder_rr
  import dmaRegConfigPkg::*;
(
  input  logic [CHANNELS-1:0] i_req,
  input  logic [PTRWIDTH-1:0] i_ptr,
  output logic [PTRWIDTH-1:0] o_winner,
  output logic                o_valid
);

  logic [PTRWIDTH-1:0] w_idx;

  // Scan from lowest to highest priority so the last hit is the winner.
  // The index addition wraps for free because CHANNELS is a power of two.
  always_comb begin
    o_winner = '0;
    w_idx    = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_idx = i_ptr + PTRWIDTH'(i);
      if (i_req[w_idx]) o_winner = w_idx;
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// dma_priority_arbiter
// Samples unmasked DREQ lines, runs the HRQ/HLDA hold handshake and grants
// exactly one channel on DACK until the service completes or hold is lost.
//   CLK     : system clock, rising edge
//   RESET_N : asynchronous active-low reset
//   bus     : master view of dma_priority_arbiter_if (requests, HLDA, mask,
//             mode, transferDone in; HRQ, DACK, activeChannel, grantValid out)
// ---------------------------------------------------------------------------
module dma_priority_arbiter
  import dmaRegConfigPkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET_N,
  dma_priority_arbiter_if.master bus
);

  arbState_t           r_state,  w_state_nxt;
  logic [PTRWIDTH-1:0] r_ptr,    w_ptr_nxt;
  logic [PTRWIDTH-1:0] r_active, w_active_nxt;
  logic                r_hrq,    w_hrq_nxt;
  logic [CHANNELS-1:0] r_dack,   w_dack_nxt;
  logic                r_gv,     w_gv_nxt;

  logic [CHANNELS-1:0] w_effReq;
  logic [PTRWIDTH-1:0] w_selPtr;
  logic [PTRWIDTH-1:0] w_winner;
  logic                w_anyReq;

  assign w_effReq = bus.controllerDisable ? '0 : (bus.DREQ & ~bus.maskBits);
  // Fixed mode ignores the stored pointer without clearing it.
  assign w_selPtr = bus.rotatingPriority ? r_ptr : '0;

  priority_encoder_rr u_enc (
    .i_req    (w_effReq),
    .i_ptr    (w_selPtr),
    .o_winner (w_winner),
    .o_valid  (w_anyReq)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_ptr_nxt    = r_ptr;
    w_active_nxt = r_active;
    w_hrq_nxt    = r_hrq;
    w_dack_nxt   = r_dack;
    w_gv_nxt     = r_gv;
    case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_state_nxt = REQUEST;
          w_hrq_nxt   = 1'b1;
        end
      end
      REQUEST: begin
        if (!w_anyReq) begin
          w_state_nxt = IDLE;
          w_hrq_nxt   = 1'b0;
        end else if (bus.HLDA) begin
          w_state_nxt          = GRANT;
          w_active_nxt         = w_winner;
          w_dack_nxt           = '0;
          w_dack_nxt[w_winner] = 1'b1;
          w_gv_nxt             = 1'b1;
        end
      end
      GRANT: begin
        // Winner is frozen; only completion or loss of hold ends the grant.
        // A completion in the same cycle as HLDA falling still counts as done.
        if (bus.transferDone || !bus.HLDA) begin
          w_state_nxt = IDLE;
          w_hrq_nxt   = 1'b0;
          w_dack_nxt  = '0;
          w_gv_nxt    = 1'b0;
          if (bus.transferDone && bus.rotatingPriority)
            w_ptr_nxt = r_active + PTRWIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hrq_nxt   = 1'b0;
        w_dack_nxt  = '0;
        w_gv_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_active <= '0;
      r_hrq    <= 1'b0;
      r_dack   <= '0;
      r_gv     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_active <= w_active_nxt;
      r_hrq    <= w_hrq_nxt;
      r_dack   <= w_dack_nxt;
      r_gv     <= w_gv_nxt;
    end
  end

  assign bus.HRQ           = r_hrq;
  assign bus.DACK          = r_dack;
  assign bus.activeChannel = r_active;
  assign bus.grantValid    = r_gv;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dma_priority_arbiter
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural bus-ownership model.
// ---------------------------------------------------------------------------
module tb_dma_priority_arbiter;
  import dmaRegConfigPkg::*;

  logic CLK = 1'b0;
  logic RESET_N;

  dma_priority_arbiter_if bus();

  dma_priority_arbiter dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks who owns the bus: nobody, "asking the CPU", or a granted channel.
  int                  m_phase;   // 0 free, 1 asking for hold, 2 channel owns bus
  int                  m_owner;
  int                  m_first;   // highest-priority channel for rotating mode
  bit                  m_hrq;
  bit                  m_gv;
  bit [CHANNELS-1:0]   m_dack;

  function automatic int pick(input bit [CHANNELS-1:0] eff, input int first);
    for (int k = 0; k < CHANNELS; k++)
      if (eff[(first + k) % CHANNELS]) return (first + k) % CHANNELS;
    return 0;
  endfunction

  always @(posedge CLK or negedge RESET_N) begin
    bit [CHANNELS-1:0] eff;
    if (!RESET_N) begin
      m_phase = 0; m_owner = 0; m_first = 0;
      m_hrq = 0; m_gv = 0; m_dack = '0;
    end else begin
      eff = bus.controllerDisable ? '0 : (bus.DREQ & ~bus.maskBits);
      if (m_phase == 0) begin
        if (eff != 0) m_phase = 1;
      end else if (m_phase == 1) begin
        if (eff == 0) m_phase = 0;
        else if (bus.HLDA) begin
          m_owner = pick(eff, bus.rotatingPriority ? m_first : 0);
          m_phase = 2;
        end
      end else begin
        if (bus.transferDone || !bus.HLDA) begin
          if (bus.transferDone && bus.rotatingPriority) m_first = (m_owner + 1) % CHANNELS;
          m_phase = 0;
        end
      end
      m_hrq  = (m_phase != 0);
      m_gv   = (m_phase == 2);
      m_dack = m_gv ? (CHANNELS'(1) << m_owner) : '0;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc_HRQ", bus.HRQ, m_hrq);
      chk("cyc_DACK", bus.DACK, m_dack);
      chk("cyc_grantValid", bus.grantValid, m_gv);
      if (m_gv) chk("cyc_activeChannel", bus.activeChannel, m_owner);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic clear_inputs();
    bus.DREQ = '0; bus.HLDA = 0; bus.maskBits = '0;
    bus.rotatingPriority = 0; bus.controllerDisable = 0; bus.transferDone = 0;
  endtask

  task automatic do_reset();
    RESET_N = 0;
    clear_inputs();
    step(2);
    RESET_N = 1;
    step(1);
  endtask

  task automatic wait_gv(input string name, input int maxc);
    int c;
    c = 0;
    while (!bus.grantValid && c < maxc) begin
      step(1);
      c++;
    end
    chk(name, bus.grantValid, 1);
  endtask

  task automatic finish_grant();
    bus.transferDone = 1;
    step(1);
    bus.transferDone = 0;
  endtask

  initial begin
    RESET_N = 0;
    clear_inputs();
    step(2);
    RESET_N = 1;
    step(1);
    cmp_en = 1;
    chk("reset_HRQ", bus.HRQ, 0);
    chk("reset_DACK", bus.DACK, 0);
    chk("reset_grantValid", bus.grantValid, 0);

    // Async reset while ch2 holds the bus
    bus.DREQ = 4'b0100; bus.HLDA = 1;
    wait_gv("rst_grant_timeout", 10);
    chk("rst_pre_DACK", bus.DACK, 4'b0100);
    #1 RESET_N = 0;
    #1;
    chk("async_HRQ", bus.HRQ, 0);
    chk("async_DACK", bus.DACK, 0);
    chk("async_grantValid", bus.grantValid, 0);
    clear_inputs();
    step(1);
    RESET_N = 1;

    // Rotating: all channels requesting; ptr must start at 0 after reset
    bus.rotatingPriority = 1; bus.DREQ = 4'b1111; bus.HLDA = 1;
    for (int g = 0; g < 5; g++) begin
      wait_gv("rot_timeout", 10);
      chk("rot_DACK", bus.DACK, 1 << (g % CHANNELS));
      finish_grant();
    end

    // Fixed priority with delayed HLDA
    do_reset();
    bus.DREQ = 4'b1010;
    step(1);
    chk("fix_HRQ_rise", bus.HRQ, 1);
    step(2);
    chk("fix_no_DACK_before_HLDA", bus.DACK, 0);
    bus.HLDA = 1;
    step(1);
    chk("fix_DACK_ch1", bus.DACK, 4'b0010);
    chk("fix_model_DACK", m_dack, 4'b0010);
    chk("fix_active", bus.activeChannel, 1);
    bus.transferDone = 1; bus.DREQ = 4'b1000;
    step(1);
    bus.transferDone = 0;
    chk("fix_done_DACK", bus.DACK, 0);
    chk("fix_done_HRQ", bus.HRQ, 0);
    step(1);
    chk("fix_rerequest_HRQ", bus.HRQ, 1);
    chk("fix_rerequest_DACK", bus.DACK, 0);
    step(1);
    chk("fix_DACK_ch3", bus.DACK, 4'b1000);
    finish_grant();

    // Masking and controller disable
    do_reset();
    bus.DREQ = 4'b0100; bus.maskBits = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("mask_HRQ", bus.HRQ, 0);
    end
    bus.maskBits = '0; bus.controllerDisable = 1; bus.DREQ = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("disable_HRQ", bus.HRQ, 0);
    end
    bus.controllerDisable = 0; bus.DREQ = '0;
    step(1);

    // Request withdrawn before HLDA
    bus.DREQ = 4'b0001;
    step(1);
    chk("wd_HRQ_1", bus.HRQ, 1);
    step(1);
    chk("wd_HRQ_2", bus.HRQ, 1);
    bus.DREQ = '0;
    step(1);
    chk("wd_HRQ_drop", bus.HRQ, 0);
    chk("wd_DACK", bus.DACK, 0);
    step(1);

    // Abort by HLDA loss: pointer must not advance
    do_reset();
    bus.rotatingPriority = 1; bus.DREQ = 4'b0010; bus.HLDA = 1;
    wait_gv("abort_grant_timeout", 10);
    chk("abort_pre_DACK", bus.DACK, 4'b0010);
    bus.HLDA = 0;
    step(1);
    chk("abort_DACK", bus.DACK, 0);
    chk("abort_HRQ", bus.HRQ, 0);
    bus.DREQ = 4'b0011;
    step(1);
    bus.HLDA = 1;
    step(1);
    chk("abort_next_DACK", bus.DACK, 4'b0001);
    chk("abort_model_owner", m_owner, 0);
    finish_grant();

    // Randomized traffic, checked every cycle by the compare process
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.DREQ = CHANNELS'($urandom);
      bus.maskBits = ($urandom_range(0, 3) == 0) ? CHANNELS'($urandom) : '0;
      bus.HLDA = ($urandom_range(0, 3) != 0) ? m_hrq : 1'($urandom_range(0, 1));
      bus.transferDone = ($urandom_range(0, 4) == 0);
      bus.controllerDisable = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 49) == 0) bus.rotatingPriority = ~bus.rotatingPriority;
      step(1);
    end

    clear_inputs();
    step(2);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Channel priority arbiter and bus-request sequencer for the DMA controller. Samples unmasked DREQ lines and runs the HRQ/HLDA hold handshake with the CPU. On hold acknowledge it grants exactly one channel via DACK and holds the grant until timing-and-control reports the service complete. Sits between the bus interface pins (DREQ, HLDA, HRQ, DACK) and the timing-and-control/datapath blocks. It drives the priorityLogic view of the bus.

## Interface
- CHANNELS, 4, number of DMA channels; taken from dmaRegConfigPkg, power of two ≥ 2
- CLK  input  1  system clock; all state changes on rising edge
- RESET_N  input  1  reset, asynchronous, active-low
- DREQ  input  CHANNELS  per-channel DMA request, active-high, level
- HLDA  input  1  CPU hold acknowledge, active-high
- maskBits  input  CHANNELS  1 = channel masked (from mask register)
- rotatingPriority  input  1  0 = fixed (ch0 highest), 1 = rotating
- controllerDisable  input  1  1 = ignore all DREQ, no new HRQ
- transferDone  input  1  one-cycle pulse from timing-and-control: current service finished (EOP or block end)
- HRQ  output  1  hold request to CPU
- DACK  output  CHANNELS  one-hot grant, active-high
- activeChannel  output  $clog2(CHANNELS)  encoded granted channel; valid while grantValid
- grantValid  output  1  high while a channel holds the bus

## Operation
- Reset values: HRQ=0, DACK=0, activeChannel=0, grantValid=0, state=IDLE, priority pointer=0.
- effReq = DREQ & ~maskBits, forced to 0 when controllerDisable=1.
- IDLE: if effReq≠0, go to REQUEST and assert HRQ.
- REQUEST: HRQ held high.
  - If effReq==0 before HLDA, drop HRQ and return to IDLE.
  - On HLDA=1 with effReq≠0, select the winner from effReq in that cycle, load activeChannel, and go to GRANT.
- GRANT: DACK[activeChannel]=1, grantValid=1, HRQ held high. Winner is frozen; new or higher-priority DREQs do not preempt.
  - On transferDone=1: clear DACK and grantValid, drop HRQ, update pointer, go to IDLE.
  - If HLDA falls during GRANT (abort): same exit as transferDone, but pointer unchanged.
- Priority: highest-priority channel is ptr; order is ptr, ptr+1, … wrapping mod CHANNELS.
  - Fixed mode: ptr forced to 0.
  - Rotating mode: on completed service of channel k, ptr ← (k+1) mod CHANNELS.
  - A mode change takes effect at the next selection. Switching to fixed does not clear the stored pointer; it is simply ignored.
- DREQ of the granted channel dropping mid-GRANT does not end the grant; only transferDone or loss of HLDA ends it.
- maskBits set on the granted channel mid-GRANT: ignored until the grant ends.
- RESET_N low in any state: immediate return to reset values, regardless of CLK.

## Timing
- effReq high at edge N → HRQ high after edge N (registered, 1-cycle latency).
- HLDA sampled high at edge M in REQUEST → DACK/grantValid high after edge M.
- transferDone sampled at edge P → DACK, grantValid and HRQ all low after edge P.
- Minimum one full cycle with HRQ=0 between consecutive grants; next HRQ can rise after edge P+1.
- DACK is always one-hot or zero, never multi-hot, and changes only on state transitions.
- HRQ stays high continuously from REQUEST entry to GRANT exit.

## Structure
- dmaRegConfigPkg: CHANNELS (existing).
- dmaRegConfigPkg additions: arbState_t enum {IDLE, REQUEST, GRANT} and PTRWIDTH = $clog2(CHANNELS).
- Sub-module priority_encoder_rr (combinational): inputs request vector and ptr; outputs winner index and any-valid. Instantiated once.
- FSM, pointer register and output registers live in dma_priority_arbiter.

## Test plan
- Reset/idle: RESET_N=0 mid-GRANT on ch2 → HRQ=0, DACK=4'b0000, grantValid=0 immediately, without waiting for CLK; ptr=0 after release.
- Fixed priority: DREQ=4'b1010, fixed mode, HLDA after 3 cycles → HRQ 1 cycle after DREQ; DACK=4'b0010 1 cycle after HLDA; transferDone → DACK=0, HRQ=0; next grant DACK=4'b1000 with at least 1 idle cycle between.
- Rotating: DREQ=4'b1111 held, HLDA high, transferDone after each grant → DACK sequence 0001, 0010, 0100, 1000, 0001.
- Masking/disable: DREQ=4'b0100 with maskBits=4'b0100 → HRQ stays 0. Set controllerDisable=1 with DREQ=4'b0001 → HRQ stays 0.
- Request withdrawn: DREQ=4'b0001 for 2 cycles, then 0, HLDA never high → HRQ pulses high 2 cycles then 0, no DACK.
- Abort: GRANT on ch1 in rotating mode, HLDA falls → DACK=0, HRQ=0 next edge; ptr unchanged, so with DREQ=4'b0011 the next grant goes to ch0.
